// File: rtl/fft_split_pkg.sv
// Shared definitions for the FFT frame splitter: split modes, channel FSM
// encoding and an elaboration-time log2 helper.
package fft_split_pkg;

  localparam logic MODE_CONTIG     = 1'b0;
  localparam logic MODE_INTERLEAVE = 1'b1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } ch_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_split_seg_buf.sv
// One output channel: SEG-deep segment buffer with a FILL/DRAIN FSM and a
// registered valid/ready/last output stage.
module fft_split_seg_buf
  import fft_split_pkg::*;
#(
  parameter int SEG    = 32,
  parameter int DATA_W = 16,
  localparam int AW    = clog2(SEG)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_wr_en,
  input  logic                i_commit,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [2*DATA_W-1:0] i_wr_data,
  input  logic                i_ready,
  output logic                o_fill,
  output logic                o_valid,
  output logic                o_last,
  output logic [2*DATA_W-1:0] o_data
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(SEG - 1);

  ch_state_e           state_q, state_d;
  logic [AW-1:0]       rptr_q, rptr_d, rptr_nxt;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [2*DATA_W-1:0] data_q, data_d;
  logic [2*DATA_W-1:0] mem_q [SEG];
  logic [2*DATA_W-1:0] mem_d [SEG];

  // Next-state, buffer write and output-register load
  always_comb begin
    state_d  = state_q;
    rptr_d   = rptr_q;
    valid_d  = valid_q;
    last_d   = last_q;
    data_d   = data_q;
    mem_d    = mem_q;
    rptr_nxt = rptr_q + AW'(1);
    case (state_q)
      ST_FILL: begin
        if (i_wr_en) begin
          mem_d[i_wr_addr] = i_wr_data;
        end else begin
          mem_d = mem_q;
        end
        // SEG >= 2, so word 0 is always already in mem_q when the segment commits
        if (i_commit) begin
          state_d = ST_DRAIN;
          rptr_d  = {AW{1'b0}};
          valid_d = 1'b1;
          last_d  = 1'b0;
          data_d  = mem_q[0];
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (valid_q && i_ready) begin
          if (rptr_q == LAST_ADDR) begin
            state_d = ST_FILL;
            rptr_d  = {AW{1'b0}};
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = {(2*DATA_W){1'b0}};
          end else begin
            rptr_d = rptr_nxt;
            data_d = mem_q[rptr_nxt];
            last_d = (rptr_nxt == LAST_ADDR);
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_FILL;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_FILL;
      rptr_q  <= {AW{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= {(2*DATA_W){1'b0}};
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // Segment storage; contents are meaningless until rewritten after reset
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_fill  = (state_q == ST_FILL);
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_data  = data_q;

endmodule

// File: rtl/fft_frame_splitter.sv
// Splits each NFFT-sample FFT frame into NCH segments, contiguous or
// interleaved, each drained through its own buffered valid/ready channel.
module fft_frame_splitter
  import fft_split_pkg::*;
#(
  parameter int LOG2_NFFT = 6,
  parameter int DATA_W    = 16,
  parameter int LOG2_NCH  = 1,
  localparam int NCH      = 1 << LOG2_NCH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_mode,
  input  logic                  i_valid,
  input  logic                  i_sof,
  input  logic [DATA_W-1:0]     i_data_i,
  input  logic [DATA_W-1:0]     i_data_q,
  output logic                  o_ready,
  output logic [NCH*DATA_W-1:0] o_data_i,
  output logic [NCH*DATA_W-1:0] o_data_q,
  output logic [NCH-1:0]        o_valid,
  output logic [NCH-1:0]        o_last,
  input  logic [NCH-1:0]        i_ready,
  output logic                  o_err_sof
);

  localparam int LOG2_SEG = LOG2_NFFT - LOG2_NCH;
  localparam int SEG      = 1 << LOG2_SEG;
  localparam logic [LOG2_NFFT-1:0] IDX_LAST  = {LOG2_NFFT{1'b1}};
  localparam logic [LOG2_SEG-1:0]  ADDR_LAST = {LOG2_SEG{1'b1}};

  logic [LOG2_NFFT-1:0] idx_q, idx_d, eff_idx;
  logic                 mode_q, mode_d, eff_mode;
  logic                 err_q, err_d;
  logic                 frame_start, xfer;
  logic [LOG2_NCH-1:0]  tgt_ch;
  logic [LOG2_SEG-1:0]  tgt_addr;
  logic [NCH-1:0]       fill_s, wr_en_s, commit_s;
  logic [2*DATA_W-1:0]  data_s [NCH];

  // Target decode, input handshake and frame bookkeeping
  always_comb begin
    frame_start = i_sof || (idx_q == {LOG2_NFFT{1'b0}});
    eff_idx     = i_sof ? {LOG2_NFFT{1'b0}} : idx_q;
    eff_mode    = frame_start ? i_mode : mode_q;
    if (eff_mode == MODE_INTERLEAVE) begin
      tgt_ch   = eff_idx[LOG2_NCH-1:0];
      tgt_addr = eff_idx[LOG2_NFFT-1:LOG2_NCH];
    end else begin
      tgt_ch   = eff_idx[LOG2_NFFT-1 -: LOG2_NCH];
      tgt_addr = eff_idx[LOG2_SEG-1:0];
    end
    o_ready = fill_s[tgt_ch];
    xfer    = i_valid && o_ready;
    // Interleaved segments complete together on the frame's final sample
    for (int k = 0; k < NCH; k++) begin
      wr_en_s[k] = xfer && (tgt_ch == LOG2_NCH'(k));
      if (eff_mode == MODE_INTERLEAVE) begin
        commit_s[k] = xfer && (eff_idx == IDX_LAST);
      end else begin
        commit_s[k] = wr_en_s[k] && (tgt_addr == ADDR_LAST);
      end
    end
    if (xfer) begin
      idx_d  = eff_idx + LOG2_NFFT'(1);
      mode_d = frame_start ? i_mode : mode_q;
      err_d  = i_sof && (idx_q != {LOG2_NFFT{1'b0}});
    end else begin
      idx_d  = idx_q;
      mode_d = mode_q;
      err_d  = 1'b0;
    end
  end

  // Frame index, latched mode and resync error pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idx_q  <= {LOG2_NFFT{1'b0}};
      mode_q <= MODE_CONTIG;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      mode_q <= mode_d;
      err_q  <= err_d;
    end
  end

  assign o_err_sof = err_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    fft_split_seg_buf #(
      .SEG    (SEG),
      .DATA_W (DATA_W)
    ) u_buf (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_wr_en   (wr_en_s[k]),
      .i_commit  (commit_s[k]),
      .i_wr_addr (tgt_addr),
      .i_wr_data ({i_data_i, i_data_q}),
      .i_ready   (i_ready[k]),
      .o_fill    (fill_s[k]),
      .o_valid   (o_valid[k]),
      .o_last    (o_last[k]),
      .o_data    (data_s[k])
    );
    assign o_data_i[k*DATA_W +: DATA_W] = data_s[k][2*DATA_W-1:DATA_W];
    assign o_data_q[k*DATA_W +: DATA_W] = data_s[k][DATA_W-1:0];
  end

endmodule

// File: tb/tb_fft_frame_splitter.sv
// Directed bench: a 2-channel and a 4-channel splitter (NFFT=16) exercised
// with contiguous/interleaved frames, backpressure, resync and reset.
module tb_fft_frame_splitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_mode, a_valid, a_sof, a_ready, a_err;
  logic [15:0] a_di, a_dq;
  logic [31:0] a_odi, a_odq;
  logic [1:0]  a_oval, a_olast, a_rdy;
  logic        b_mode, b_valid, b_sof, b_ready, b_err;
  logic [15:0] b_di, b_dq;
  logic [63:0] b_odi, b_odq;
  logic [3:0]  b_oval, b_olast, b_rdy;

  fft_frame_splitter #(.LOG2_NFFT(4), .DATA_W(16), .LOG2_NCH(1)) u_dut2 (
    .i_clk(clk), .i_reset(reset), .i_mode(a_mode), .i_valid(a_valid), .i_sof(a_sof),
    .i_data_i(a_di), .i_data_q(a_dq), .o_ready(a_ready), .o_data_i(a_odi),
    .o_data_q(a_odq), .o_valid(a_oval), .o_last(a_olast), .i_ready(a_rdy),
    .o_err_sof(a_err));

  fft_frame_splitter #(.LOG2_NFFT(4), .DATA_W(16), .LOG2_NCH(2)) u_dut4 (
    .i_clk(clk), .i_reset(reset), .i_mode(b_mode), .i_valid(b_valid), .i_sof(b_sof),
    .i_data_i(b_di), .i_data_q(b_dq), .o_ready(b_ready), .o_data_i(b_odi),
    .o_data_q(b_odq), .o_valid(b_oval), .o_last(b_olast), .i_ready(b_rdy),
    .o_err_sof(b_err));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int last_stamp = 0;
  int first_stall = -1;

  logic [32:0] ca [2][64];
  int          sa [2][64];
  int          na [2];
  logic [32:0] cb [4][64];
  int          sb [4][64];
  int          nb [4];
  int          err_a, err_b;
  logic        clr;

  // Output monitor: records every channel transfer with its cycle stamp
  always @(negedge clk) begin
    if (clr) begin
      for (int k = 0; k < 2; k++) na[k] <= 0;
      for (int k = 0; k < 4; k++) nb[k] <= 0;
      err_a <= 0;
      err_b <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (a_oval[k] && a_rdy[k]) begin
          if (na[k] < 64) begin
            ca[k][na[k]] <= {a_olast[k], a_odq[k*16 +: 16], a_odi[k*16 +: 16]};
            sa[k][na[k]] <= cyc;
          end
          na[k] <= na[k] + 1;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (b_oval[k] && b_rdy[k]) begin
          if (nb[k] < 64) begin
            cb[k][nb[k]] <= {b_olast[k], b_odq[k*16 +: 16], b_odi[k*16 +: 16]};
            sb[k][nb[k]] <= cyc;
          end
          nb[k] <= nb[k] + 1;
        end
      end
      if (a_err) err_a <= err_a + 1;
      if (b_err) err_b <= err_b + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] word(input int v, input logic last);
    logic [15:0] s;
    s = v[15:0];
    return {last, s ^ 16'h5A5A, s};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rst();
    reset = 1'b1; clr = 1'b1;
    a_valid = 1'b0; a_sof = 1'b0; b_valid = 1'b0; b_sof = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0; clr = 1'b0;
  endtask

  // Offer one sample to DUT sel (0 = 2-channel, 1 = 4-channel), bounded wait
  task automatic send(input int sel, input int v, input logic sof, input logic mode);
    int cnt;
    logic rd;
    if (sel == 0) begin
      a_valid = 1'b1; a_sof = sof; a_mode = mode; a_di = v[15:0]; a_dq = v[15:0] ^ 16'h5A5A;
    end else begin
      b_valid = 1'b1; b_sof = sof; b_mode = mode; b_di = v[15:0]; b_dq = v[15:0] ^ 16'h5A5A;
    end
    cnt = 0;
    @(negedge clk);
    rd = (sel == 0) ? a_ready : b_ready;
    while (!rd && cnt < 100) begin
      if (first_stall < 0) first_stall = v;
      @(negedge clk);
      cnt++;
      rd = (sel == 0) ? a_ready : b_ready;
    end
    if (!rd) check_eq("send_timeout", 64'd0, 64'd1);
    last_stamp = cyc;
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_sof = 1'b0; b_valid = 1'b0; b_sof = 1'b0;
  endtask

  initial begin
    int c;
    int s7;
    reset = 1'b1; clr = 1'b1;
    a_mode = 1'b0; a_valid = 1'b0; a_sof = 1'b0; a_di = 16'h0; a_dq = 16'h0; a_rdy = 2'b11;
    b_mode = 1'b0; b_valid = 1'b0; b_sof = 1'b0; b_di = 16'h0; b_dq = 16'h0; b_rdy = 4'hF;
    s7 = 0;
    rst();

    @(negedge clk);
    check_eq("rst_a_ready", a_ready, 1);
    check_eq("rst_a_valid", a_oval, 0);
    check_eq("rst_a_last",  a_olast, 0);
    check_eq("rst_a_data",  {a_odi, a_odq}, 0);
    check_eq("rst_a_err",   a_err, 0);
    check_eq("rst_b_ready", b_ready, 1);
    check_eq("rst_b_valid", b_oval, 0);
    @(posedge clk); #1;

    // Contiguous split, 2 channels
    for (int i = 0; i < 16; i++) begin
      send(0, 64 + i, i == 0, 1'b0);
      if (i == 7) s7 = last_stamp;
    end
    idle(20);
    check_eq("t1_cnt0", na[0], 8);
    check_eq("t1_cnt1", na[1], 8);
    for (int j = 0; j < 8; j++) begin
      check_eq("t1_ch0", ca[0][j], word(64 + j, j == 7));
      check_eq("t1_ch1", ca[1][j], word(72 + j, j == 7));
    end
    check_eq("t1_lat0", sa[0][0] - s7, 1);
    check_eq("t1_lat1", sa[1][0] - last_stamp, 1);
    check_eq("t1_no_err", err_a, 0);

    // Interleaved split, 4 channels
    rst();
    for (int i = 0; i < 16; i++) send(1, 100 + i, i == 0, 1'b1);
    idle(20);
    for (int k = 0; k < 4; k++) begin
      check_eq("t2_cnt", nb[k], 4);
      check_eq("t2_rise", sb[k][0] - last_stamp, 1);
      for (int j = 0; j < 4; j++) check_eq("t2_data", cb[k][j], word(100 + k + 4*j, j == 3));
    end

    // Backpressure on channel 0 across two back-to-back frames
    rst();
    a_rdy = 2'b10;
    first_stall = -1;
    fork
      begin
        for (int i = 0; i < 32; i++) send(0, 300 + i, (i % 16) == 0, 1'b0);
      end
      begin
        c = 0;
        while (first_stall < 0 && c < 300) begin @(negedge clk); c++; end
        check_eq("t3_stall_at", first_stall, 316);
        check_eq("t3_hold_valid", a_oval[0], 1);
        check_eq("t3_hold_word", {a_olast[0], a_odq[15:0], a_odi[15:0]}, word(300, 1'b0));
        check_eq("t3_not_ready", a_ready, 0);
        repeat (4) @(negedge clk);
        check_eq("t3_hold_word2", {a_olast[0], a_odq[15:0], a_odi[15:0]}, word(300, 1'b0));
        check_eq("t3_not_ready2", a_ready, 0);
        @(posedge clk); #1;
        a_rdy = 2'b11;
      end
    join
    idle(40);
    check_eq("t3_cnt0", na[0], 16);
    check_eq("t3_cnt1", na[1], 16);
    for (int j = 0; j < 8; j++) begin
      check_eq("t3_ch0_f1", ca[0][j],     word(300 + j, j == 7));
      check_eq("t3_ch0_f2", ca[0][8 + j], word(316 + j, j == 7));
      check_eq("t3_ch1_f1", ca[1][j],     word(308 + j, j == 7));
      check_eq("t3_ch1_f2", ca[1][8 + j], word(324 + j, j == 7));
    end

    // Mid-frame start-of-frame resync at idx 5
    rst();
    for (int i = 0; i < 21; i++) send(0, 500 + i, (i == 0) || (i == 5), 1'b0);
    idle(30);
    check_eq("t4_err_pulses", err_a, 1);
    check_eq("t4_cnt0", na[0], 8);
    check_eq("t4_cnt1", na[1], 8);
    for (int j = 0; j < 8; j++) begin
      check_eq("t4_ch0", ca[0][j], word(505 + j, j == 7));
      check_eq("t4_ch1", ca[1][j], word(513 + j, j == 7));
    end

    // Mode toggled at idx 3 affects only the following frame
    rst();
    for (int i = 0; i < 16; i++) send(1, 700 + i, i == 0, i >= 3);
    for (int i = 0; i < 16; i++) send(1, 800 + i, i == 0, 1'b1);
    idle(30);
    for (int k = 0; k < 4; k++) begin
      check_eq("t5_cnt", nb[k], 8);
      for (int j = 0; j < 4; j++) begin
        check_eq("t5_f1_contig", cb[k][j],     word(700 + 4*k + j, j == 3));
        check_eq("t5_f2_inter",  cb[k][4 + j], word(800 + k + 4*j, j == 3));
      end
    end
    check_eq("t5_no_err", err_b, 0);

    // Reset while channel 1 is draining
    rst();
    for (int i = 0; i < 16; i++) send(0, 900 + i, i == 0, 1'b0);
    c = 0;
    while (na[1] < 3 && c < 100) begin @(posedge clk); #1; c++; end
    check_eq("t6_reached_drain", na[1], 3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t6_valid", a_oval, 0);
    check_eq("t6_last",  a_olast, 0);
    check_eq("t6_data",  {a_odi, a_odq}, 0);
    check_eq("t6_ready", a_ready, 1);
    rst();
    for (int i = 0; i < 16; i++) send(0, 950 + i, i == 0, 1'b0);
    idle(20);
    check_eq("t6_cnt0", na[0], 8);
    check_eq("t6_cnt1", na[1], 8);
    for (int j = 0; j < 8; j++) begin
      check_eq("t6_ch0", ca[0][j], word(950 + j, j == 7));
      check_eq("t6_ch1", ca[1][j], word(958 + j, j == 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
